// File: rtl/ysyx_22050058_div_gen.sv
// ysyx_22050058_div_gen
// Iterative restoring integer divider for the EX stage.
// Supports signed/unsigned and 32-bit word (W) operations per request.
// Divide-by-zero and signed overflow follow the RISC-V results.
// Retires BITS_PER_CYCLE quotient bits per cycle.
// The result is held in DONE until the consumer accepts it.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   flush_i           abort any operation; return to IDLE
//   div_valid_i       request strobe (sampled in IDLE only)
//   div_signed_i      1 = signed DIV/REM
//   div_word_i        1 = W operation on bits [31:0], results sign-extended
//   div_dividend_i    dividend
//   div_divisor_i     divisor
//   div_out_ready_i   consumer accepts the result in DONE
//   div_busy_o        high in CALC and DONE
//   div_out_valid_o   high in DONE
//   div_quotient_o    registered quotient
//   div_remainder_o   registered remainder
module ysyx_22050058_div_gen #(
    parameter int WIDTH          = 64,
    parameter int BITS_PER_CYCLE = 1,
    parameter int HAS_WORD       = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             div_valid_i,
    input  logic             div_signed_i,
    input  logic             div_word_i,
    input  logic [WIDTH-1:0] div_dividend_i,
    input  logic [WIDTH-1:0] div_divisor_i,
    input  logic             div_out_ready_i,
    output logic             div_busy_o,
    output logic             div_out_valid_o,
    output logic [WIDTH-1:0] div_quotient_o,
    output logic [WIDTH-1:0] div_remainder_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH / BITS_PER_CYCLE);
    localparam logic [CW-1:0] CNT_WORD = CW'(32 / BITS_PER_CYCLE);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t state_reg, state_next;

    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] dsr_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] quo_reg;
    logic             word_reg;
    logic             neg_q_reg;
    logic             neg_r_reg;
    logic [WIDTH-1:0] q_out_reg;
    logic [WIDTH-1:0] r_out_reg;

    function automatic logic [WIDTH-1:0] sext_word(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] y;
        y = x;
        for (int i = 32; i < WIDTH; i++) y[i] = x[31];
        return y;
    endfunction

    // Request decode: N-bit operand views, magnitudes and special cases
    logic             word_eff;
    logic [WIDTH-1:0] dvd_ext, dsr_ext, dvd_mag, dsr_mag, quo_init;
    logic             dvd_neg, dsr_neg, dsr_zero, ovf, special;
    logic [WIDTH-1:0] special_q, special_r;

    assign word_eff = (HAS_WORD != 0) && div_word_i;

    always_comb begin
        dvd_ext = div_dividend_i;
        dsr_ext = div_divisor_i;
        if (word_eff) begin
            dvd_ext = div_signed_i ? sext_word(div_dividend_i) : WIDTH'(div_dividend_i[31:0]);
            dsr_ext = div_signed_i ? sext_word(div_divisor_i)  : WIDTH'(div_divisor_i[31:0]);
        end
        dvd_neg = div_signed_i & dvd_ext[WIDTH-1];
        dsr_neg = div_signed_i & dsr_ext[WIDTH-1];
        dvd_mag = dvd_neg ? -dvd_ext : dvd_ext;
        dsr_mag = dsr_neg ? -dsr_ext : dsr_ext;
        // Word dividends sit in the top 32 bits so the same MSB-first
        // shift works; the low zeros end up above the quotient bits.
        quo_init = word_eff ? (dvd_mag << (WIDTH - 32)) : dvd_mag;

        dsr_zero = word_eff ? (div_divisor_i[31:0] == 32'd0) : (div_divisor_i == '0);
        ovf      = div_signed_i & (word_eff ?
                   (div_dividend_i[31:0] == 32'h8000_0000 && div_divisor_i[31:0] == 32'hFFFF_FFFF) :
                   (div_dividend_i == MIN_NEG && div_divisor_i == '1));
        special  = dsr_zero | ovf;

        special_q = dsr_zero ? '1 : dvd_ext;
        special_r = dsr_zero ? dvd_ext : '0;
        if (word_eff) begin
            special_q = sext_word(special_q);
            special_r = sext_word(special_r);
        end
    end

    // Restoring shift-subtract, BITS_PER_CYCLE steps per clock
    logic [WIDTH-1:0] r_step, q_step;

    always_comb begin
        logic [WIDTH:0] shifted;
        logic           ge;
        r_step  = rem_reg;
        q_step  = quo_reg;
        shifted = '0;
        ge      = 1'b0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            shifted = {r_step, q_step[WIDTH-1]};
            ge      = shifted >= {1'b0, dsr_reg};
            // The true difference is below the divisor, so it fits WIDTH bits.
            r_step  = ge ? (shifted[WIDTH-1:0] - dsr_reg) : shifted[WIDTH-1:0];
            q_step  = {q_step[WIDTH-2:0], ge};
        end
    end

    // Sign fixup and word-mode extension of the final step
    logic [WIDTH-1:0] q_fix, r_fix, q_res, r_res;

    always_comb begin
        q_fix = neg_q_reg ? -q_step : q_step;
        r_fix = neg_r_reg ? -r_step : r_step;
        q_res = word_reg ? sext_word(q_fix) : q_fix;
        r_res = word_reg ? sext_word(r_fix) : r_fix;
    end

    // FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (flush_i) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: if (div_valid_i) state_next = special ? S_DONE : S_CALC;
                S_CALC: if (cnt_reg == CNT_ONE) state_next = S_DONE;
                S_DONE: if (div_out_ready_i) state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg   <= '0;
            dsr_reg   <= '0;
            rem_reg   <= '0;
            quo_reg   <= '0;
            word_reg  <= 1'b0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
            q_out_reg <= '0;
            r_out_reg <= '0;
        end else if (!flush_i) begin
            if (state_reg == S_IDLE && div_valid_i) begin
                dsr_reg   <= dsr_mag;
                rem_reg   <= '0;
                quo_reg   <= quo_init;
                word_reg  <= word_eff;
                neg_q_reg <= dvd_neg ^ dsr_neg;
                neg_r_reg <= dvd_neg;
                cnt_reg   <= word_eff ? CNT_WORD : CNT_FULL;
                if (special) begin
                    q_out_reg <= special_q;
                    r_out_reg <= special_r;
                end
            end else if (state_reg == S_CALC) begin
                rem_reg <= r_step;
                quo_reg <= q_step;
                cnt_reg <= cnt_reg - CNT_ONE;
                if (cnt_reg == CNT_ONE) begin
                    q_out_reg <= q_res;
                    r_out_reg <= r_res;
                end
            end
        end
    end

    assign div_busy_o      = (state_reg != S_IDLE);
    assign div_out_valid_o = (state_reg == S_DONE);
    assign div_quotient_o  = q_out_reg;
    assign div_remainder_o = r_out_reg;

endmodule

// File: tb/tb_ysyx_22050058_div_gen.sv
module tb_ysyx_22050058_div_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        valid1 = 1'b0, valid2 = 1'b0;
    logic        sgn = 1'b0, word = 1'b0;
    logic [63:0] dvd = '0, dsr = '0;
    logic        ready1 = 1'b1, ready2 = 1'b1;
    logic        busy1, ov1, busy2, ov2;
    logic [63:0] q1, r1, q2, r2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ysyx_22050058_div_gen #(.WIDTH(64), .BITS_PER_CYCLE(1), .HAS_WORD(1)) dut (
        .clk(clk), .rst(rst), .flush_i(flush), .div_valid_i(valid1),
        .div_signed_i(sgn), .div_word_i(word), .div_dividend_i(dvd),
        .div_divisor_i(dsr), .div_out_ready_i(ready1), .div_busy_o(busy1),
        .div_out_valid_o(ov1), .div_quotient_o(q1), .div_remainder_o(r1)
    );

    ysyx_22050058_div_gen #(.WIDTH(64), .BITS_PER_CYCLE(2), .HAS_WORD(1)) dut2 (
        .clk(clk), .rst(rst), .flush_i(flush), .div_valid_i(valid2),
        .div_signed_i(sgn), .div_word_i(word), .div_dividend_i(dvd),
        .div_divisor_i(dsr), .div_out_ready_i(ready2), .div_busy_o(busy2),
        .div_out_valid_o(ov2), .div_quotient_o(q2), .div_remainder_o(r2)
    );

    // Reference: plain arithmetic with the RISC-V special cases.
    function automatic void ref_div(input logic [63:0] a, input logic [63:0] b,
                                    input bit s, input bit w,
                                    output logic [63:0] q, output logic [63:0] r);
        logic [31:0] a32, b32, q32, r32;
        a32 = a[31:0];
        b32 = b[31:0];
        if (w) begin
            if (b32 == 0) begin q32 = '1; r32 = a32; end
            else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin q32 = a32; r32 = 0; end
            else if (s) begin q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32); end
            else begin q32 = a32 / b32; r32 = a32 % b32; end
            q = {{32{q32[31]}}, q32};
            r = {{32{r32[31]}}, r32};
        end else begin
            if (b == 0) begin q = '1; r = a; end
            else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin q = a; r = 0; end
            else if (s) begin q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); end
            else begin q = a / b; r = a % b; end
        end
    endfunction

    function automatic int ref_lat(input logic [63:0] a, input logic [63:0] b,
                                   input bit s, input bit w, input int bpc);
        bit zero, ovf;
        zero = w ? (b[31:0] == 0) : (b == 0);
        ovf  = s && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                       : (a == 64'h8000_0000_0000_0000 && b == '1));
        if (zero || ovf) return 0;
        return (w ? 32 : 64) / bpc;
    endfunction

    // Drives one request (called at a negedge); returns the result and the
    // number of clock edges after the accepting edge until out_valid is seen.
    task automatic run_op(input bit sel, input logic [63:0] a, input logic [63:0] b,
                          input bit s, input bit w,
                          output logic [63:0] q, output logic [63:0] r, output int lat);
        dvd = a; dsr = b; sgn = s; word = w;
        if (sel) valid2 = 1'b1; else valid1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid1 = 1'b0; valid2 = 1'b0;
        dvd = {$urandom, $urandom}; dsr = {$urandom, $urandom};
        sgn = ~s; word = ~w;
        lat = 0;
        while (!(sel ? ov2 : ov1) && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        q = sel ? q2 : q1;
        r = sel ? r2 : r1;
    endtask

    task automatic gen(output logic [63:0] a, output logic [63:0] b, output bit s, output bit w);
        s = 1'($urandom_range(0, 1));
        w = 1'($urandom_range(0, 1));
        a = {$urandom, $urandom};
        case ($urandom_range(0, 5))
            0: b = {$urandom, $urandom};
            1: b = 64'($urandom_range(1, 15));
            2: b = 64'd0;
            3: begin b = '1; a = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000; end
            4: b = -64'($urandom_range(1, 9));
            default: begin b = {32'd0, $urandom}; a = a >> $urandom_range(0, 40); end
        endcase
    endtask

    task automatic test_reset();
        total++;
        if (busy1 !== 1'b0 || ov1 !== 1'b0 || q1 !== 64'd0 || r1 !== 64'd0) begin
            bad++;
            $display("FAIL reset1: busy=%b valid=%b q=%h r=%h, want all 0", busy1, ov1, q1, r1);
        end
        total++;
        if (busy2 !== 1'b0 || ov2 !== 1'b0 || q2 !== 64'd0 || r2 !== 64'd0) begin
            bad++;
            $display("FAIL reset2: busy=%b valid=%b q=%h r=%h, want all 0", busy2, ov2, q2, r2);
        end
        $display("reset check done");
    endtask

    task automatic test_directed();
        logic [63:0] ta [8] = '{64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd5, 64'd5,
                                64'h8000_0000_0000_0000, 64'h0000_0001_8000_0000,
                                64'h1234_5678_FFFF_FFF9, 64'h0000_0000_FFFF_FFFE};
        logic [63:0] tb [8] = '{64'd7, 64'd2, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF,
                                64'h0000_0000_FFFF_FFFF, 64'd2, 64'd1};
        bit          ts [8] = '{0, 1, 0, 1, 1, 1, 1, 0};
        bit          tw [8] = '{0, 0, 0, 0, 0, 1, 1, 1};
        logic [63:0] eq [8] = '{64'd14, 64'hFFFF_FFFF_FFFF_FFFD, '1, '1,
                                64'h8000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000,
                                64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFE};
        logic [63:0] er [8] = '{64'd2, '1, 64'd5, 64'd5, 64'd0, 64'd0, '1, 64'd0};
        int          el [8] = '{64, 64, 0, 0, 0, 0, 32, 32};
        logic [63:0] q, r;
        int lat;
        for (int i = 0; i < 8; i++) begin
            run_op(1'b0, ta[i], tb[i], ts[i], tw[i], q, r, lat);
            total++;
            if (q !== eq[i] || r !== er[i] || lat != el[i]) begin
                bad++;
                $display("FAIL directed%0d: q=%h r=%h lat=%0d, want q=%h r=%h lat=%0d",
                         i, q, r, lat, eq[i], er[i], el[i]);
            end
            @(negedge clk);
            total++;
            if (ov1 !== 1'b0 || busy1 !== 1'b0) begin
                bad++;
                $display("FAIL pulse%0d: valid=%b busy=%b after handshake, want 0 0", i, ov1, busy1);
            end
            $display("directed %0d: %h / %h s=%0d w=%0d -> q=%h r=%h lat=%0d", i, ta[i], tb[i], ts[i], tw[i], q, r, lat);
        end
    endtask

    task automatic test_random(input bit sel, input int n);
        logic [63:0] a, b, q, r, mq, mr;
        bit s, w;
        int lat, elat;
        for (int i = 0; i < n; i++) begin
            gen(a, b, s, w);
            ref_div(a, b, s, w, mq, mr);
            elat = ref_lat(a, b, s, w, sel ? 2 : 1);
            run_op(sel, a, b, s, w, q, r, lat);
            total++;
            if (q !== mq || r !== mr || lat != elat) begin
                bad++;
                $display("FAIL random%0d_%0d: q=%h r=%h lat=%0d, want q=%h r=%h lat=%0d",
                         sel, i, q, r, lat, mq, mr, elat);
            end
            @(negedge clk);
            $display("random bpc=%0d %0d: %h / %h s=%0d w=%0d -> q=%h r=%h lat=%0d",
                     sel ? 2 : 1, i, a, b, s, w, q, r, lat);
        end
    endtask

    task automatic test_stall();
        logic [63:0] q, r, mq, mr;
        int lat;
        ready1 = 1'b0;
        ref_div(64'hFFFF_FFFF_FFFF_FF00, 64'd10, 1'b1, 1'b0, mq, mr);
        run_op(1'b0, 64'hFFFF_FFFF_FFFF_FF00, 64'd10, 1'b1, 1'b0, q, r, lat);
        total++;
        if (q !== mq || r !== mr || lat != 64) begin
            bad++;
            $display("FAIL stall_result: q=%h r=%h lat=%0d, want q=%h r=%h lat=64", q, r, lat, mq, mr);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (ov1 !== 1'b1 || busy1 !== 1'b1 || q1 !== q || r1 !== r) begin
                bad++;
                $display("FAIL stall_hold%0d: valid=%b busy=%b q=%h r=%h, want 1 1 %h %h", i, ov1, busy1, q1, r1, q, r);
            end
        end
        ready1 = 1'b1;
        @(negedge clk);
        total++;
        if (ov1 !== 1'b0 || busy1 !== 1'b0) begin
            bad++;
            $display("FAIL stall_release: valid=%b busy=%b, want 0 0", ov1, busy1);
        end
        $display("stall: held q=%h r=%h for 5 cycles", q, r);
    endtask

    task automatic test_flush();
        logic [63:0] q, r;
        int lat;
        // Flush on CALC cycle 10
        dvd = 64'd1000; dsr = 64'd3; sgn = 1'b0; word = 1'b0; valid1 = 1'b1;
        @(posedge clk); @(negedge clk);
        valid1 = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        total++;
        if (busy1 !== 1'b0 || ov1 !== 1'b0) begin
            bad++;
            $display("FAIL flush_calc: busy=%b valid=%b, want 0 0", busy1, ov1);
        end
        // New request the cycle after the flush
        run_op(1'b0, 64'd100, 64'd7, 1'b0, 1'b0, q, r, lat);
        total++;
        if (q !== 64'd14 || r !== 64'd2 || lat != 64) begin
            bad++;
            $display("FAIL flush_next: q=%h r=%h lat=%0d, want 14 2 64", q, r, lat);
        end
        @(negedge clk);
        // Flush beats a new request in IDLE
        dvd = 64'd9; dsr = 64'd0; valid1 = 1'b1; flush = 1'b1;
        @(negedge clk);
        valid1 = 1'b0; flush = 1'b0;
        total++;
        if (busy1 !== 1'b0 || ov1 !== 1'b0) begin
            bad++;
            $display("FAIL flush_idle: busy=%b valid=%b, want 0 0", busy1, ov1);
        end
        // Flush beats the handshake in DONE
        ready1 = 1'b0;
        run_op(1'b0, 64'd9, 64'd0, 1'b0, 1'b0, q, r, lat);
        flush = 1'b1; ready1 = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        total++;
        if (busy1 !== 1'b0 || ov1 !== 1'b0 || lat != 0) begin
            bad++;
            $display("FAIL flush_done: busy=%b valid=%b lat=%0d, want 0 0 0", busy1, ov1, lat);
        end
        $display("flush: calc/idle/done flushes checked");
    endtask

    task automatic test_reset_mid();
        dvd = 64'd12345; dsr = 64'd11; sgn = 1'b0; word = 1'b0; valid1 = 1'b1;
        @(posedge clk); @(negedge clk);
        valid1 = 1'b0;
        repeat (20) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        total++;
        if (busy1 !== 1'b0 || ov1 !== 1'b0 || q1 !== 64'd0 || r1 !== 64'd0) begin
            bad++;
            $display("FAIL reset_mid: busy=%b valid=%b q=%h r=%h, want all 0", busy1, ov1, q1, r1);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (70) begin
            @(negedge clk);
            if (ov1 !== 1'b0) break;
        end
        total++;
        if (ov1 !== 1'b0 || busy1 !== 1'b0) begin
            bad++;
            $display("FAIL reset_after: valid=%b busy=%b, want 0 0", ov1, busy1);
        end
        $display("reset mid-CALC checked");
    endtask

    task automatic test_bpc2();
        logic [63:0] q, r;
        int lat;
        run_op(1'b1, 64'd100, 64'd7, 1'b0, 1'b0, q, r, lat);
        total++;
        if (q !== 64'd14 || r !== 64'd2 || lat != 32) begin
            bad++;
            $display("FAIL bpc2_100_7: q=%h r=%h lat=%0d, want 14 2 32", q, r, lat);
        end
        @(negedge clk);
        run_op(1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 1'b1, 1'b1, q, r, lat);
        total++;
        if (q !== 64'hFFFF_FFFF_FFFF_FFFD || r !== '1 || lat != 16) begin
            bad++;
            $display("FAIL bpc2_divw: q=%h r=%h lat=%0d, want fffffffffffffffd ffffffffffffffff 16", q, r, lat);
        end
        @(negedge clk);
        $display("bpc2 directed checked");
        test_random(1'b1, 12);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_directed();
        test_random(1'b0, 30);
        test_stall();
        test_flush();
        test_reset_mid();
        test_bpc2();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
